// File: rtl/irq_controller.sv
// Interrupt controller sitting upstream of the CPU core.
// It keeps per-source enable/edge/pending state and presents one request at a
// time on IRQ/IRQn, using the lowest pending+enabled index first.
// After the CPU acknowledges, no new request is raised until software writes
// the STATUS register (end-of-interrupt).
// Handshake: IRQ/IRQn are held stable from the request until IRQAck is
// sampled high. The next edge drops IRQ and enters service.
// A request is only started when IRQAck is low.
module irq_controller #(
  parameter int          NSRC      = 8,
  parameter logic [11:0] VEC_BASE  = 12'h100,
  parameter int          VEC_SHIFT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src,
  input  logic            cfgWrEn,
  input  logic [1:0]      cfgAddr,
  input  logic [31:0]     cfgDataIn,
  output logic [31:0]     cfgDataOut,
  output logic            IRQ,
  output logic [11:0]     IRQn,
  input  logic            IRQAck
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t          state, state_next;
  logic [NSRC-1:0] enable, edge_cfg, pending, src_prev;
  logic [NSRC-1:0] cand, w1c, claim, pending_next;
  logic [3:0]      active_idx, active_next, cand_idx;
  logic            cand_any;
  logic [11:0]     cand_vec, irqn_next;
  logic            irq_next;
  logic            wr_enable, wr_pending, wr_edge, eoi;
  logic [31:0]     rd_data;

  assign wr_enable  = cfgWrEn && (cfgAddr == 2'd0);
  assign wr_pending = cfgWrEn && (cfgAddr == 2'd1);
  assign wr_edge    = cfgWrEn && (cfgAddr == 2'd2);
  assign eoi        = cfgWrEn && (cfgAddr == 2'd3);

  assign cand     = pending & enable;
  assign w1c      = wr_pending ? cfgDataIn[NSRC-1:0] : '0;
  assign cand_vec = VEC_BASE + ({8'd0, cand_idx} << VEC_SHIFT);

  // Fixed priority: lowest set candidate index wins.
  always_comb begin
    cand_any = 1'b0;
    cand_idx = 4'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        cand_any = 1'b1;
        cand_idx = 4'(i);
      end
    end
  end

  // Pending update: edge bits set on rising src, cleared by W1C or claim
  // (a set in the same cycle wins); level bits simply follow src.
  always_comb begin
    claim = '0;
    for (int i = 0; i < NSRC; i++) begin
      claim[i] = (state == REQ) && IRQAck && edge_cfg[i] && (active_idx == 4'(i));
    end
    pending_next = (edge_cfg & ((pending & ~w1c & ~claim) | (src & ~src_prev)))
                 | (~edge_cfg & src);
  end

  // Request FSM next-state and registered-output values.
  always_comb begin
    state_next  = state;
    irq_next    = IRQ;
    irqn_next   = IRQn;
    active_next = active_idx;
    case (state)
      IDLE: begin
        if (cand_any && !IRQAck) begin
          state_next  = REQ;
          irq_next    = 1'b1;
          irqn_next   = cand_vec;
          active_next = cand_idx;
        end
      end
      REQ: begin
        if (IRQAck) begin
          state_next = SERVICE;
          irq_next   = 1'b0;
        end
      end
      SERVICE: begin
        if (eoi) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        irq_next   = 1'b0;
      end
    endcase
  end

  // Register read mux; values reflect state before any same-cycle write.
  always_comb begin
    rd_data = '0;
    case (cfgAddr)
      2'd0: rd_data[NSRC-1:0] = enable;
      2'd1: rd_data[NSRC-1:0] = pending;
      2'd2: rd_data[NSRC-1:0] = edge_cfg;
      default: begin
        rd_data[0]   = (state == SERVICE);
        rd_data[1]   = IRQ;
        rd_data[7:4] = active_idx;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Configuration, pending, request outputs and read data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      enable     <= '0;
      edge_cfg   <= '0;
      pending    <= '0;
      src_prev   <= '0;
      IRQ        <= 1'b0;
      IRQn       <= 12'd0;
      active_idx <= 4'd0;
      cfgDataOut <= 32'd0;
    end else begin
      if (wr_enable) enable   <= cfgDataIn[NSRC-1:0];
      if (wr_edge)   edge_cfg <= cfgDataIn[NSRC-1:0];
      pending    <= pending_next;
      src_prev   <= src;
      IRQ        <= irq_next;
      IRQn       <= irqn_next;
      active_idx <= active_next;
      cfgDataOut <= rd_data;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: expected vectors are queued when a
// request is provoked and popped when IRQ is seen.
module tb_irq_controller;

  logic        clk, rst;
  logic [7:0]  src;
  logic        cfgWrEn;
  logic [1:0]  cfgAddr;
  logic [31:0] cfgDataIn;
  logic [31:0] cfgDataOut, cfgDataOut2;
  logic        IRQ, IRQ2, IRQAck;
  logic [11:0] IRQn, IRQn2;

  logic [11:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  irq_controller #(.NSRC(8), .VEC_BASE(12'h100), .VEC_SHIFT(2)) dut (
    .clk(clk), .rst(rst), .src(src), .cfgWrEn(cfgWrEn), .cfgAddr(cfgAddr),
    .cfgDataIn(cfgDataIn), .cfgDataOut(cfgDataOut), .IRQ(IRQ), .IRQn(IRQn),
    .IRQAck(IRQAck)
  );

  // Second instance with a base near the top of the 12-bit space.
  irq_controller #(.NSRC(8), .VEC_BASE(12'hFF8), .VEC_SHIFT(2)) dut_wrap (
    .clk(clk), .rst(rst), .src(src), .cfgWrEn(cfgWrEn), .cfgAddr(cfgAddr),
    .cfgDataIn(cfgDataIn), .cfgDataOut(cfgDataOut2), .IRQ(IRQ2), .IRQn(IRQn2),
    .IRQAck(IRQAck)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfgWrEn = 1'b1; cfgAddr = a; cfgDataIn = d;
    tick();
    cfgWrEn = 1'b0; cfgDataIn = 32'd0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    cfgAddr = a;
    tick();
    tick();
    d = cfgDataOut;
  endtask

  task automatic wait_irq(input int max, output int cyc);
    cyc = 0;
    while (IRQ !== 1'b1 && cyc < max) begin
      tick();
      cyc++;
    end
  endtask

  function automatic logic [11:0] pop_exp();
    if (exp_q.size() == 0) return 12'hxxx;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    logic [11:0] e;
    rst = 1'b1; src = '0; cfgWrEn = 1'b0; cfgAddr = 2'd0; cfgDataIn = '0; IRQAck = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_checks++;
    if (IRQ !== 1'b0 || IRQn !== 12'h000 || cfgDataOut !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got IRQ=%b IRQn=%h dout=%h, required 0/000/0", IRQ, IRQn, cfgDataOut);
    end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      n_checks++;
      if (d !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h, required 0", a, d);
      end
    end
    e = 12'h000;
    n_checks++;
    if (exp_q.size() != 0 || e !== IRQn) begin
      n_fail++;
      $display("FAIL reset_idle: got IRQn=%h, required 000", IRQn);
    end
  endtask

  task automatic test_single_edge();
    logic [31:0] d;
    logic [11:0] e;
    wr(2'd0, 32'h01);
    wr(2'd2, 32'h01);
    exp_q.push_back(12'h100);
    src[0] = 1'b1;
    tick();
    src[0] = 1'b0;
    n_checks++;
    if (IRQ !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_early: got IRQ=%b one edge after pulse, required 0", IRQ);
    end
    tick();
    e = pop_exp();
    n_checks++;
    if (IRQ !== 1'b1 || IRQn !== e) begin
      n_fail++;
      $display("FAIL edge_latency: got IRQ=%b IRQn=%h, required 1/%h", IRQ, IRQn, e);
    end
    IRQAck = 1'b1;
    tick();
    IRQAck = 1'b0;
    n_checks++;
    if (IRQ !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_ack_drop: got IRQ=%b, required 0", IRQ);
    end
    rd(2'd1, d);
    n_checks++;
    if (d !== 32'h00) begin
      n_fail++;
      $display("FAIL edge_claim: got PENDING=%h, required 00", d);
    end
    rd(2'd3, d);
    n_checks++;
    if (d !== 32'h01) begin
      n_fail++;
      $display("FAIL edge_status: got STATUS=%h, required 01", d);
    end
    wr(2'd3, 32'h0);
    rd(2'd3, d);
    n_checks++;
    if (d !== 32'h00) begin
      n_fail++;
      $display("FAIL edge_eoi: got STATUS=%h, required 00", d);
    end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    logic [11:0] e;
    int cyc;
    wr(2'd0, 32'h24);
    wr(2'd2, 32'h25);
    exp_q.push_back(12'h108);
    exp_q.push_back(12'h114);
    src = 8'h24;
    tick();
    src = 8'h00;
    wait_irq(5, cyc);
    e = pop_exp();
    n_checks++;
    if (IRQ !== 1'b1 || IRQn !== e) begin
      n_fail++;
      $display("FAIL prio_first: got IRQ=%b IRQn=%h, required 1/%h", IRQ, IRQn, e);
    end
    IRQAck = 1'b1;
    tick();
    IRQAck = 1'b0;
    rd(2'd1, d);
    n_checks++;
    if (d !== 32'h20) begin
      n_fail++;
      $display("FAIL prio_pending: got PENDING=%h, required 20", d);
    end
    wr(2'd3, 32'h0);
    n_checks++;
    if (IRQ !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_idle_entry: got IRQ=%b, required 0", IRQ);
    end
    tick();
    e = pop_exp();
    n_checks++;
    if (IRQ !== 1'b1 || IRQn !== e) begin
      n_fail++;
      $display("FAIL prio_second: got IRQ=%b IRQn=%h, required 1/%h", IRQ, IRQn, e);
    end
    wr(2'd3, 32'h0);
    tick();
    n_checks++;
    if (IRQ !== 1'b1 || IRQn !== e) begin
      n_fail++;
      $display("FAIL prio_eoi_in_req: got IRQ=%b IRQn=%h, required 1/%h", IRQ, IRQn, e);
    end
    IRQAck = 1'b1;
    tick();
    IRQAck = 1'b0;
    rd(2'd3, d);
    n_checks++;
    if (d !== 32'h51) begin
      n_fail++;
      $display("FAIL prio_status: got STATUS=%h, required 51", d);
    end
    wr(2'd3, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [11:0] e;
    int cyc;
    wr(2'd0, 32'h01);
    exp_q.push_back(12'h100);
    src[0] = 1'b1;
    tick();
    src[0] = 1'b0;
    wait_irq(5, cyc);
    e = pop_exp();
    n_checks++;
    if (IRQ !== 1'b1 || IRQn !== e) begin
      n_fail++;
      $display("FAIL b2b_first: got IRQ=%b IRQn=%h, required 1/%h", IRQ, IRQn, e);
    end
    IRQAck = 1'b1;
    tick();
    IRQAck = 1'b0;
    src[0] = 1'b1;
    tick();
    src[0] = 1'b0;
    tick();
    rd(2'd1, d);
    n_checks++;
    if (d !== 32'h01) begin
      n_fail++;
      $display("FAIL b2b_repend: got PENDING=%h, required 01", d);
    end
    exp_q.push_back(12'h100);
    wr(2'd3, 32'h0);
    tick();
    e = pop_exp();
    n_checks++;
    if (IRQ !== 1'b1 || IRQn !== e) begin
      n_fail++;
      $display("FAIL b2b_rerequest: got IRQ=%b IRQn=%h, required 1/%h", IRQ, IRQn, e);
    end
    IRQAck = 1'b1;
    tick();
    IRQAck = 1'b0;
    wr(2'd3, 32'h0);
  endtask

  task automatic test_level();
    logic [31:0] d;
    logic [11:0] e;
    int cyc;
    wr(2'd0, 32'h08);
    exp_q.push_back(12'h10C);
    src[3] = 1'b1;
    wait_irq(5, cyc);
    e = pop_exp();
    n_checks++;
    if (IRQ !== 1'b1 || IRQn !== e) begin
      n_fail++;
      $display("FAIL level_req: got IRQ=%b IRQn=%h, required 1/%h", IRQ, IRQn, e);
    end
    n_checks++;
    if (IRQ2 !== 1'b1 || IRQn2 !== 12'h004) begin
      n_fail++;
      $display("FAIL vec_wrap: got IRQ=%b IRQn=%h, required 1/004", IRQ2, IRQn2);
    end
    IRQAck = 1'b1;
    tick();
    IRQAck = 1'b0;
    wr(2'd1, 32'h08);
    rd(2'd1, d);
    n_checks++;
    if (d !== 32'h08) begin
      n_fail++;
      $display("FAIL level_w1c: got PENDING=%h, required 08", d);
    end
    exp_q.push_back(12'h10C);
    wr(2'd3, 32'h0);
    tick();
    e = pop_exp();
    n_checks++;
    if (IRQ !== 1'b1 || IRQn !== e) begin
      n_fail++;
      $display("FAIL level_rerequest: got IRQ=%b IRQn=%h, required 1/%h", IRQ, IRQn, e);
    end
    IRQAck = 1'b1;
    tick();
    IRQAck = 1'b0;
    src[3] = 1'b0;
    tick();
    wr(2'd3, 32'h0);
    repeat (4) tick();
    n_checks++;
    if (IRQ !== 1'b0) begin
      n_fail++;
      $display("FAIL level_dropped: got IRQ=%b, required 0", IRQ);
    end
    rd(2'd1, d);
    n_checks++;
    if (d !== 32'h00) begin
      n_fail++;
      $display("FAIL level_pending_clear: got PENDING=%h, required 00", d);
    end
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    logic [11:0] e;
    wr(2'd0, 32'h00);
    // Read in the same cycle as a write returns the old value.
    n_checks++;
    if (cfgDataOut !== 32'h08) begin
      n_fail++;
      $display("FAIL read_during_write: got %h, required 08", cfgDataOut);
    end
    wr(2'd2, 32'h02);
    src[1] = 1'b1;
    tick();
    src[1] = 1'b0;
    tick();
    wr(2'd1, 32'h02);
    rd(2'd1, d);
    n_checks++;
    if (d !== 32'h00) begin
      n_fail++;
      $display("FAIL w1c_clear: got PENDING=%h, required 00", d);
    end
    src[1] = 1'b1;
    cfgWrEn = 1'b1; cfgAddr = 2'd1; cfgDataIn = 32'h02;
    tick();
    cfgWrEn = 1'b0; cfgDataIn = 32'h0; src[1] = 1'b0;
    rd(2'd1, d);
    n_checks++;
    if (d !== 32'h02) begin
      n_fail++;
      $display("FAIL set_wins: got PENDING=%h, required 02", d);
    end
    n_checks++;
    if (IRQ !== 1'b0) begin
      n_fail++;
      $display("FAIL disabled_no_irq: got IRQ=%b, required 0", IRQ);
    end
    exp_q.push_back(12'h104);
    wr(2'd0, 32'h02);
    n_checks++;
    if (IRQ !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_early: got IRQ=%b, required 0", IRQ);
    end
    tick();
    e = pop_exp();
    n_checks++;
    if (IRQ !== 1'b1 || IRQn !== e) begin
      n_fail++;
      $display("FAIL enable_request: got IRQ=%b IRQn=%h, required 1/%h", IRQ, IRQn, e);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [11:0] e;
    logic seen;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (IRQ !== 1'b0 || IRQn !== 12'h000) begin
      n_fail++;
      $display("FAIL midrst_irq: got IRQ=%b IRQn=%h, required 0/000", IRQ, IRQn);
    end
    rd(2'd0, d);
    n_checks++;
    if (d !== 32'h00) begin
      n_fail++;
      $display("FAIL midrst_enable: got ENABLE=%h, required 00", d);
    end
    rd(2'd1, d);
    n_checks++;
    if (d !== 32'h00) begin
      n_fail++;
      $display("FAIL midrst_pending: got PENDING=%h, required 00", d);
    end
    wr(2'd0, 32'h01);
    wr(2'd2, 32'h01);
    IRQAck = 1'b1;
    src[0] = 1'b1;
    tick();
    src[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen |= IRQ;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_high_hold: got IRQ=%b while IRQAck high, required 0", seen);
    end
    exp_q.push_back(12'h100);
    IRQAck = 1'b0;
    tick();
    e = pop_exp();
    n_checks++;
    if (IRQ !== 1'b1 || IRQn !== e) begin
      n_fail++;
      $display("FAIL ack_low_request: got IRQ=%b IRQn=%h, required 1/%h", IRQ, IRQn, e);
    end
    IRQAck = 1'b1;
    tick();
    IRQAck = 1'b0;
    wr(2'd3, 32'h0);
  endtask

  // Test sequence and final report.
  initial begin
    test_reset();
    test_single_edge();
    test_priority();
    test_back_to_back();
    test_level();
    test_set_wins();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
